// File: rtl/shift_sequencer_pkg.sv
// Shared constants and encodings for the shift sequencer and its stage shifter.
// Five log-shift stages, one per clock, process amounts 16, 8, 4, 2 and 1.
package shift_sequencer_pkg;

  localparam int SEQ_WIDTH  = 32;
  localparam int SEQ_STAGES = 5;

  // The stage index starts here and counts down to zero.
  localparam logic [2:0] STG_FIRST = 3'd4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_SRL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_stage.sv
// Combinational single-stage shifter: shifts acc by 2^stg when enabled.
// It holds no state; the sequencer owns every register.
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       stg,
  input  logic [1:0]       op,
  input  logic             en,
  output logic [WIDTH-1:0] nxt
);

  logic [SEQ_STAGES-1:0] amt;

  assign amt = SEQ_STAGES'(1) << stg;

  always_comb begin
    nxt = acc;
    if (en) begin
      case (op_e'(op))
        // Sign fill comes from acc[31] as it stands at the start of this stage.
        OP_SRA:  nxt = $signed(acc) >>> amt;
        OP_SRL:  nxt = acc >> amt;
        default: nxt = acc << amt;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one log stage per clock, fixed 6-cycle latency,
// with abort, back-to-back acceptance from DONE and a held result register.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH  = SEQ_WIDTH,
  parameter int STAGES = SEQ_STAGES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [STAGES-1:0] shamt,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result
);

  state_e            state_q, state_d;
  logic [2:0]        stg_q, stg_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [1:0]        op_q, op_d;
  logic [STAGES-1:0] shamt_q, shamt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  acc_nxt;

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .acc (acc_q),
    .stg (stg_q),
    .op  (op_q),
    .en  (shamt_q[stg_q]),
    .nxt (acc_nxt)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    stg_d    = stg_q;
    acc_d    = acc_q;
    op_d     = op_q;
    shamt_d  = shamt_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_SHIFT;
          stg_d   = STG_FIRST;
          acc_d   = data_in;
          op_d    = op;
          shamt_d = shamt;
        end
      end
      ST_SHIFT: begin
        // Abort wins over the stage that would otherwise complete on this edge.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_nxt;
          if (stg_q == 3'd0) begin
            state_d  = ST_DONE;
            result_d = acc_nxt;
          end else begin
            stg_d = stg_q - 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      stg_q    <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      shamt_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      stg_q    <= stg_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, shift ops, start-ignore, abort,
// mid-operation reset and back-to-back acceptance.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [1:0]  op      = 2'b00;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt   = '0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] e;
  } vec_t;

  always #5 clock = ~clock;

  shift_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
    op = o; data_in = d; shamt = s; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
  endtask

  // Counts falling-edge samples from the one after acceptance (n=1) until done.
  task automatic wait_done(output int n, output logic [31:0] r);
    n = 1;
    while (done !== 1'b1 && n < 12) begin
      @(negedge clock);
      n++;
    end
    r = result;
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] r;
    #2;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      fails++;
      $display("FAIL reset_state busy=%b done=%b result=%h want 0 0 00000000", busy, done, result);
    end
    @(negedge clock);
    reset_n = 1'b1;
    issue(OP_SLL, 32'h5, 5'd1);
    wait_done(n, r);
    tests++;
    if (n != 6 || r !== 32'hA) begin
      fails++;
      $display("FAIL first_edge_accept latency=%0d result=%h want 6 0000000a", n, r);
    end
    @(negedge clock);
  endtask

  task automatic test_shifts();
    vec_t vecs[11];
    int n;
    logic [31:0] r;
    vecs[0]  = '{OP_SRA, 32'h80000000, 5'd16, 32'hFFFF8000};
    vecs[1]  = '{OP_SLL, 32'h00000001, 5'd31, 32'h80000000};
    vecs[2]  = '{OP_SRL, 32'h80000000, 5'd4,  32'h08000000};
    vecs[3]  = '{OP_SLL, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[4]  = '{OP_SRA, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[5]  = '{OP_SRL, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[6]  = '{OP_RSV, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[7]  = '{OP_SRA, 32'h40000000, 5'd5,  32'h02000000};
    vecs[8]  = '{OP_RSV, 32'h00000003, 5'd2,  32'h0000000C};
    vecs[9]  = '{OP_SRA, 32'h80000001, 5'd31, 32'hFFFFFFFF};
    vecs[10] = '{OP_SRL, 32'hFFFFFFFF, 5'd31, 32'h00000001};
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].d, vecs[i].s);
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_after_accept[%0d] busy=%b want 1", i, busy);
      end
      wait_done(n, r);
      tests++;
      if (n != 6 || r !== vecs[i].e || busy !== 1'b0) begin
        fails++;
        $display("FAIL shift[%0d] latency=%0d result=%h busy=%b want 6 %h 0", i, n, r, busy, vecs[i].e);
      end
      @(negedge clock);
      tests++;
      if (done !== 1'b0 || result !== vecs[i].e) begin
        fails++;
        $display("FAIL done_one_cycle[%0d] done=%b result=%h want 0 %h", i, done, result, vecs[i].e);
      end
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    int done_at  = 0;
    logic [31:0] r = '0;
    issue(OP_SLL, 32'h1234, 5'd1);
    for (int n = 2; n <= 14; n++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        done_cnt++;
        done_at = n;
        r = result;
      end
      if (n == 2 || n == 3) begin
        start = 1'b1; op = OP_SRL; data_in = 32'hFFFF0000; shamt = 5'd3;
      end else begin
        start = 1'b0; op = OP_SLL; data_in = '0; shamt = '0;
      end
    end
    tests++;
    if (done_cnt != 1 || done_at != 6 || r !== 32'h2468) begin
      fails++;
      $display("FAIL start_ignored dones=%0d at=%0d result=%h want 1 6 00002468", done_cnt, done_at, r);
    end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    issue(OP_SLL, 32'h1, 5'd1);
    @(negedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_exit busy=%b done=%b want 0 0", busy, done);
    end
    repeat (8) begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
    end
    tests++;
    if (done_cnt != 0 || result !== 32'h2468) begin
      fails++;
      $display("FAIL abort_no_done dones=%0d result=%h want 0 00002468", done_cnt, result);
    end
    // Abort while idle must not block acceptance.
    abort = 1'b1;
    issue(OP_SLL, 32'h1, 5'd1);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_in_idle busy=%b want 1", busy);
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    issue(OP_SRA, 32'h80000000, 5'd16);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid busy=%b done=%b result=%h want 0 0 00000000", busy, done, result);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
    end
    tests++;
    if (done_cnt != 0 || result !== 32'h0) begin
      fails++;
      $display("FAIL reset_discard dones=%0d result=%h want 0 00000000", done_cnt, result);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [31:0] r1, r2;
    issue(OP_SRA, 32'hF0000000, 5'd4);
    wait_done(n1, r1);
    tests++;
    if (n1 != 6 || r1 !== 32'hFF000000) begin
      fails++;
      $display("FAIL b2b_first latency=%0d result=%h want 6 ff000000", n1, r1);
    end
    issue(OP_SRL, 32'hF0000000, 5'd4);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy, done);
    end
    wait_done(n2, r2);
    tests++;
    if (n2 != 6 || r2 !== 32'h0F000000) begin
      fails++;
      $display("FAIL b2b_second latency=%0d result=%h want 6 0f000000", n2, r2);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
